// File: rtl/cacheline_adapter.sv
// Cache-line <-> 4x64-bit burst adapter between cache and memory.
// Optional perf counters: define CACHELINE_ADAPTER_PERF_EN.
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_k;
  logic [31:0]  r_addr;
  logic [255:0] r_wline;
  logic [255:0] r_line;
  logic [7:0]   w_base;
  logic         w_last;

  assign w_base = {r_k, 6'b0};
  assign w_last = resp_i && (r_k == 2'd3);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state decode; write wins over read
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (write_i)     w_next = S_WRITE;
        else if (read_i) w_next = S_READ;
      end
      S_READ:  if (w_last) w_next = S_DONE;
      S_WRITE: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
    endcase
  end

  // request latching, beat counter and fill assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= 2'd0;
      r_addr  <= 32'd0;
      r_wline <= 256'd0;
      r_line  <= 256'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (write_i || read_i) begin
            r_addr <= address_i;
            r_k    <= 2'd0;
          end
          if (write_i) r_wline <= line_i;
        end
        S_READ: begin
          if (resp_i) begin
            r_line[w_base +: 64] <= burst_i;
            r_k                  <= r_k + 2'd1;
          end
        end
        S_WRITE: begin
          if (resp_i) r_k <= r_k + 2'd1;
        end
        S_DONE: ;
      endcase
    end
  end

  assign address_o = r_addr & ~32'h1F;
  assign read_o    = (r_state == S_READ);
  assign write_o   = (r_state == S_WRITE);
  assign resp_o    = (r_state == S_DONE);
  assign line_o    = r_line;
  assign burst_o   = r_wline[w_base +: 64];

`ifdef CACHELINE_ADAPTER_PERF_EN
  int num_fills;
  int num_writebacks;
  int num_stall_cycles;

  // burst completion and memory stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      num_fills        <= 0;
      num_writebacks   <= 0;
      num_stall_cycles <= 0;
    end else begin
      if (r_state == S_READ && w_last)
        num_fills <= num_fills + 1;
      if (r_state == S_WRITE && w_last)
        num_writebacks <= num_writebacks + 1;
      if ((read_o || write_o) && !resp_i)
        num_stall_cycles <= num_stall_cycles + 1;
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Scoreboard bench for cacheline_adapter.
// Stimulus pushes expectations; a negedge monitor checks them.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         resp_i;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .resp_i    (resp_i)
  );

  typedef struct {
    logic [255:0] line;
    int           cyc;
  } exp_t;

  exp_t         rq[$];
  logic [63:0]  wq[$];
  int           checks;
  int           fails;
  int           cyc;
  logic [31:0]  cur_addr;
  bit           cur_wr;
  logic [255:0] last_line;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n,
                     input logic [255:0] a,
                     input logic [255:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h",
               n, a, e);
    end
  endtask

  // monitor: address/kind during bursts, write beats, completions
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (read_o || write_o) begin
        chk("address_o", address_o, cur_addr);
        chk("kind", read_o, !cur_wr);
        if (write_o) begin
          if (wq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL wbeat_unexpected actual=%0h required=none",
                     burst_o);
          end else begin
            chk("burst_o", burst_o, wq[0]);
            if (resp_i) void'(wq.pop_front());
          end
        end
      end
      if (resp_o) begin
        if (rq.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL resp_spurious actual=1 required=0 cyc=%0d",
                   cyc);
        end else begin
          e = rq.pop_front();
          chk("line_o", line_o, e.line);
          chk("resp_cyc", cyc, e.cyc);
          chk("rw_in_done", {read_o, write_o}, 2'b00);
        end
      end
    end
  end

  task automatic burst(input bit rdreq,
                       input bit wrreq,
                       input logic [31:0] a,
                       input logic [255:0] wl,
                       input logic [255:0] rb,
                       input int w[4],
                       input bit keep_rd);
    int c0;
    int nw;
    nw = w[0] + w[1] + w[2] + w[3];
    cur_addr = a & ~32'h1F;
    cur_wr   = wrreq;
    if (wrreq) begin
      for (int k = 0; k < 4; k++)
        wq.push_back(wl[64*k +: 64]);
    end else begin
      last_line = rb;
    end
    address_i = a;
    line_i    = wl;
    read_i    = rdreq;
    write_i   = wrreq;
    @(posedge clk); #1;
    c0 = cyc;
    rq.push_back('{last_line, c0 + 4 + nw});
    address_i = ~a;
    line_i    = ~wl;
    for (int k = 0; k < 4; k++) begin
      repeat (w[k]) begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
        @(posedge clk); #1;
      end
      resp_i  = 1'b1;
      burst_i = rb[64*k +: 64];
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    @(posedge clk); #1;
    write_i = 1'b0;
    if (!keep_rd) read_i = 1'b0;
  endtask

  initial begin
    logic [255:0] rA;
    logic [255:0] wB;
    logic [255:0] wC;
    logic [255:0] rC;
    logic [255:0] wD;
    logic [255:0] rD;
    logic [255:0] rE;
    checks    = 0;
    fails     = 0;
    cyc       = 0;
    cur_addr  = 32'd0;
    cur_wr    = 1'b0;
    last_line = 256'd0;
    rst       = 1'b1;
    address_i = 32'd0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    line_i    = 256'd0;
    burst_i   = 64'd0;
    resp_i    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_read_o", read_o, 1'b0);
    chk("rst_write_o", write_o, 1'b0);
    chk("rst_line_o", line_o, 256'd0);
    chk("rst_address_o", address_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    rA = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    burst(1, 0, 32'h1234_567F, 256'd0, rA,
          '{0, 0, 0, 0}, 0);

    wB = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    burst(0, 1, 32'h0000_ABCD, wB, 256'd0,
          '{0, 0, 2, 0}, 0);

    resp_i  = 1'b1;
    burst_i = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    resp_i = 1'b0;
    chk("idle_resp_ignored", line_o, rA);
    chk("idle_no_read", read_o, 1'b0);

    wC = {64'hC3C3_0000_0000_0003,
          64'hC2C2_0000_0000_0002,
          64'hC1C1_0000_0000_0001,
          64'hC0C0_0000_0000_0000};
    rC = {64'h1111_2222_3333_4444,
          64'h5555_6666_7777_8888,
          64'h9999_AAAA_BBBB_CCCC,
          64'hDDDD_EEEE_FFFF_0000};
    burst(1, 1, 32'hFFFF_FFE1, wC, 256'd0,
          '{1, 0, 0, 0}, 1);
    burst(1, 0, 32'h8000_0040, 256'd0, rC,
          '{0, 1, 0, 1}, 0);

    wD = {64'h0123_4567_89AB_CDEF,
          64'hFEDC_BA98_7654_3210,
          64'h0F0F_0F0F_0F0F_0F0F,
          64'hF0F0_F0F0_F0F0_F0F0};
    rD = {64'h0000_0000_0000_0044,
          64'h0000_0000_0000_0033,
          64'h0000_0000_0000_0022,
          64'h0000_0000_0000_0011};
    burst(0, 1, 32'h0040_0020, wD, 256'd0,
          '{0, 0, 0, 0}, 0);
    burst(1, 0, 32'h0040_0020, 256'd0, rD,
          '{0, 0, 0, 0}, 0);

    cur_addr  = 32'h0BAD_0000;
    cur_wr    = 1'b0;
    address_i = 32'h0BAD_001F;
    read_i    = 1'b1;
    @(posedge clk); #1;
    address_i = 32'd0;
    resp_i    = 1'b1;
    burst_i   = 64'hB0;
    @(posedge clk); #1;
    burst_i   = 64'hB1;
    @(posedge clk); #1;
    resp_i = 1'b0;
    rst    = 1'b1;
    read_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_read_o", read_o, 1'b0);
    chk("abort_line_o", line_o, 256'd0);
    chk("abort_resp_o", resp_o, 1'b0);
    chk("abort_address_o", address_o, 32'd0);
    rst       = 1'b0;
    last_line = 256'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_resp", resp_o, 1'b0);

    rE = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    burst(1, 0, 32'h0BAD_001F, 256'd0, rE,
          '{0, 0, 0, 0}, 0);

    for (int i = 0; i < 20; i++) begin
      if (rq.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("resp_queue_drained", rq.size(), 0);
    chk("wbeat_queue_drained", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
